// File: rtl/msk_timing_pkg.sv
// Shared constants and types for the MSK symbol timing recovery path.
// Accumulator and step are fixed point: INT_W.MU_W raw samples.
package msk_timing_pkg;

    localparam int OSF   = 20;
    localparam int MU_W  = 27;
    localparam int INT_W = 5;
    localparam int ACC_W = INT_W + MU_W;

    typedef logic        [ACC_W-1:0] acc_t;
    typedef logic        [MU_W:0]    step_t;
    typedef logic signed [MU_W+1:0]  ctrl_t;
    typedef logic        [MU_W-1:0]  mu_t;

    localparam step_t ONE_SAMPLE   = step_t'(1 << MU_W);
    localparam acc_t  SYM_WRAP     = {OSF[INT_W-1:0], {MU_W{1'b0}}};
    localparam step_t STEP_MIN_DEF = step_t'(1 << (MU_W - 1));
    localparam step_t STEP_MAX_DEF = step_t'(3 << (MU_W - 1));

endpackage

// File: rtl/timing_step_sat.sv
// Registered step = clamp(nominal + signed correction). The add is carried
// two bits wider than the step so both clamp directions see the true sum.
module timing_step_sat
    import msk_timing_pkg::*;
#(
    parameter step_t NOMINAL  = ONE_SAMPLE,
    parameter step_t STEP_MIN = STEP_MIN_DEF,
    parameter step_t STEP_MAX = STEP_MAX_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  ctrl_t ctrl_i,
    output step_t step_o
);

    logic signed [MU_W+2:0] sum;
    logic signed [MU_W+2:0] lo;
    logic signed [MU_W+2:0] hi;
    step_t                  step_d;
    step_t                  step_q;

    assign lo  = signed'({2'b00, STEP_MIN});
    assign hi  = signed'({2'b00, STEP_MAX});
    assign sum = signed'({2'b00, NOMINAL}) + signed'({ctrl_i[MU_W+1], ctrl_i});

    always_comb begin
        step_d = sum[MU_W:0];
        if (sum < lo)
            step_d = STEP_MIN;
        else if (sum > hi)
            step_d = STEP_MAX;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            step_q <= NOMINAL;
        else if (load_i)
            step_q <= step_d;
    end

    assign step_o = step_q;

endmodule

// File: rtl/timing_nco.sv
// Interpolator-control NCO: one phase advance per valid raw sample, strobing
// at each symbol wrap with the residual phase as the interpolator delay.
module timing_nco
    import msk_timing_pkg::*;
#(
    parameter acc_t  INIT_PH  = '0,
    parameter int    CNT_W    = 16,
    parameter step_t STEP_MIN = STEP_MIN_DEF,
    parameter step_t STEP_MAX = STEP_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             iq_raw_val_i,
    input  ctrl_t            loop_ctrl_i,
    input  logic             loop_val_i,
    input  acc_t             ph_load_i,
    input  logic             ph_load_val_i,
    output logic [INT_W-1:0] phase_int_o,
    output mu_t              mu_o,
    output logic             phase_val_o,
    output logic             sym_valid_o,
    output logic [CNT_W-1:0] sym_cnt_o
);

    step_t            step_q;
    acc_t             acc_q, acc_d, acc_adv, load_red;
    logic [ACC_W:0]   sum_s;
    logic             wrap, adv;
    logic [INT_W-1:0] pi_q, pi_d;
    mu_t              mu_q, mu_d;
    logic             pv_q, pv_d, sv_q, sv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Step register updates take effect on the advance after they are captured.
    timing_step_sat #(
        .NOMINAL (ONE_SAMPLE),
        .STEP_MIN(STEP_MIN),
        .STEP_MAX(STEP_MAX)
    ) u_step (
        .clk   (clk),
        .rst   (rst),
        .load_i(loop_val_i),
        .ctrl_i(loop_ctrl_i),
        .step_o(step_q)
    );

    assign adv   = en_i & iq_raw_val_i;
    assign sum_s = {1'b0, acc_q} + {{INT_W{1'b0}}, step_q};
    assign wrap  = sum_s >= {1'b0, SYM_WRAP};
    // True residual always fits ACC_W bits, so modular subtract is exact.
    assign acc_adv  = wrap ? (sum_s[ACC_W-1:0] - SYM_WRAP) : sum_s[ACC_W-1:0];
    assign load_red = (ph_load_i >= SYM_WRAP) ? (ph_load_i - SYM_WRAP) : ph_load_i;

    always_comb begin
        acc_d = acc_q;
        pv_d  = 1'b0;
        sv_d  = 1'b0;
        pi_d  = pi_q;
        mu_d  = mu_q;
        cnt_d = cnt_q;
        if (ph_load_val_i) begin
            acc_d = load_red;
            pv_d  = adv;
        end else if (adv) begin
            acc_d = acc_adv;
            pv_d  = 1'b1;
            if (wrap) begin
                sv_d         = 1'b1;
                {pi_d, mu_d} = acc_adv;
                cnt_d        = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= INIT_PH;
            pv_q  <= 1'b0;
            sv_q  <= 1'b0;
            pi_q  <= '0;
            mu_q  <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            pv_q  <= pv_d;
            sv_q  <= sv_d;
            pi_q  <= pi_d;
            mu_q  <= mu_d;
            cnt_q <= cnt_d;
        end
    end

    assign phase_int_o = pi_q;
    assign mu_o        = mu_q;
    assign phase_val_o = pv_q;
    assign sym_valid_o = sv_q;
    assign sym_cnt_o   = cnt_q;

endmodule

// File: tb/tb_timing_nco.sv
// Directed + random bench for timing_nco with a reference-model scoreboard.
module tb_timing_nco;

    localparam longint ONE  = 64'd1 << 27;
    localparam longint HALF = 64'd1 << 26;
    localparam longint WRAP = 64'd20 << 27;
    localparam longint SMIN = 64'd1 << 26;
    localparam longint SMAX = 64'd3 << 26;

    typedef struct packed {
        logic        pv;
        logic        sv;
        logic [4:0]  pi;
        logic [26:0] mu;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_i = 1'b0, iq_raw_val_i = 1'b0, loop_val_i = 1'b0, ph_load_val_i = 1'b0;
    logic [28:0] loop_ctrl_i = '0;
    logic [31:0] ph_load_i = '0;
    logic [4:0]  phase_int_o;
    logic [26:0] mu_o;
    logic        phase_val_o, sym_valid_o;
    logic [15:0] sym_cnt_o;

    timing_nco dut (
        .clk(clk), .rst(rst), .en_i(en_i), .iq_raw_val_i(iq_raw_val_i),
        .loop_ctrl_i(loop_ctrl_i), .loop_val_i(loop_val_i),
        .ph_load_i(ph_load_i), .ph_load_val_i(ph_load_val_i),
        .phase_int_o(phase_int_o), .mu_o(mu_o), .phase_val_o(phase_val_o),
        .sym_valid_o(sym_valid_o), .sym_cnt_o(sym_cnt_o)
    );

    always #5 clk = ~clk;

    int     n_chk = 0;
    int     n_err = 0;
    exp_t   sb[$];
    longint m_acc = 0, m_step = ONE, m_pi = 0, m_mu = 0, m_cnt = 0;
    exp_t   obs;

    task automatic chk(input string tag, input longint o, input longint e);
        n_chk++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Drive one clock of stimulus, push model prediction, compare after the edge.
    task automatic cyc(input bit r, input bit en, input bit val, input bit lv,
                       input longint lc, input bit ldv, input longint ld);
        exp_t   e;
        longint s, old_step;
        rst = r; en_i = en; iq_raw_val_i = val; loop_val_i = lv;
        loop_ctrl_i = lc[28:0]; ph_load_val_i = ldv; ph_load_i = ld[31:0];
        e = '0;
        if (!r) begin
            m_acc = 0; m_step = ONE; m_pi = 0; m_mu = 0; m_cnt = 0;
        end else begin
            old_step = m_step;
            if (lv) begin
                s = ONE + lc;
                m_step = (s < SMIN) ? SMIN : (s > SMAX) ? SMAX : s;
            end
            if (ldv) begin
                m_acc = (ld >= WRAP) ? ld - WRAP : ld;
                e.pv  = en && val;
            end else if (en && val) begin
                e.pv = 1'b1;
                s = m_acc + old_step;
                if (s >= WRAP) begin
                    m_acc = s - WRAP;
                    e.sv  = 1'b1;
                    m_pi  = m_acc / ONE;
                    m_mu  = m_acc % ONE;
                    m_cnt = (m_cnt + 1) % 65536;
                end else begin
                    m_acc = s;
                end
            end
        end
        e.pi = m_pi[4:0]; e.mu = m_mu[26:0]; e.cnt = m_cnt[15:0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        obs = {phase_val_o, sym_valid_o, phase_int_o, mu_o, sym_cnt_o};
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("sb_pv",  obs.pv,  e.pv);
            chk("sb_sv",  obs.sv,  e.sv);
            chk("sb_pi",  obs.pi,  e.pi);
            chk("sb_mu",  obs.mu,  e.mu);
            chk("sb_cnt", obs.cnt, e.cnt);
        end
    endtask

    task automatic samp();
        cyc(1, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_pv", obs.pv, 0); chk("rst_sv", obs.sv, 0);
        chk("rst_pi", obs.pi, 0); chk("rst_mu", obs.mu, 0); chk("rst_cnt", obs.cnt, 0);

        // Nominal step: strobes at samples 20, 40, 60
        for (int i = 1; i <= 60; i++) begin
            samp();
            chk("nom_sv", obs.sv, (i % 20 == 0) ? 1 : 0);
            if (i % 20 == 0) begin
                chk("nom_pi", obs.pi, 0); chk("nom_mu", obs.mu, 0);
            end
        end
        chk("nom_cnt", obs.cnt, 3);

        // Step 1.25: strobe every 16 samples
        do_reset();
        cyc(1, 1, 0, 1, 64'd1 << 25, 0, 0);
        for (int i = 1; i <= 32; i++) begin
            samp();
            chk("s125_sv", obs.sv, (i % 16 == 0) ? 1 : 0);
            if (i % 16 == 0) begin
                chk("s125_pi", obs.pi, 0); chk("s125_mu", obs.mu, 0);
            end
        end

        // Requested 2.0 clamps to 1.5
        do_reset();
        cyc(1, 1, 0, 1, 64'd1 << 27, 0, 0);
        for (int i = 1; i <= 27; i++) begin
            samp();
            chk("clmp_sv", obs.sv, (i == 14 || i == 27) ? 1 : 0);
            if (i == 14) begin chk("clmp_pi14", obs.pi, 1); chk("clmp_mu14", obs.mu, 0); end
            if (i == 27) begin chk("clmp_pi27", obs.pi, 0); chk("clmp_mu27", obs.mu, HALF); end
        end

        // Coarse load 19.5, then a sample wraps to residual 0.5
        do_reset();
        cyc(1, 1, 0, 0, 0, 1, (64'd19 << 27) | HALF);
        samp();
        chk("ld_sv", obs.sv, 1); chk("ld_pi", obs.pi, 0); chk("ld_mu", obs.mu, HALF);
        // Load coincident with a sample: phase valid but no strobe
        cyc(1, 1, 1, 0, 0, 1, (64'd19 << 27) | HALF);
        chk("ldc_pv", obs.pv, 1); chk("ldc_sv", obs.sv, 0);
        samp();
        chk("ldc_next_sv", obs.sv, 1);
        // Out-of-range load reduced once: 21.0 -> 1.0, wrap on 19th sample
        cyc(1, 1, 0, 0, 0, 1, 64'd21 << 27);
        for (int i = 1; i <= 19; i++) begin
            samp();
            chk("ldr_sv", obs.sv, (i == 19) ? 1 : 0);
        end

        // Gapped samples: every 3rd clock valid, strobes 60 clocks apart
        do_reset();
        for (int i = 1; i <= 120; i++) begin
            cyc(1, 1, (i % 3 == 0), 0, 0, 0, 0);
            chk("gap_sv", obs.sv, (i == 60 || i == 120) ? 1 : 0);
        end
        // Frozen enable: no phase valid, no strobe, counting resumes intact
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 1, 0, 0, 0, 0);
            chk("frz_pv", obs.pv, 0); chk("frz_sv", obs.sv, 0);
        end
        for (int i = 1; i <= 20; i++) begin
            samp();
            chk("frz_res_sv", obs.sv, (i == 20) ? 1 : 0);
        end

        // Reset on the cycle a wrap is due
        do_reset();
        for (int i = 1; i <= 19; i++) samp();
        cyc(0, 1, 1, 0, 0, 0, 0);
        chk("rwr_sv", obs.sv, 0); chk("rwr_pv", obs.pv, 0);
        chk("rwr_pi", obs.pi, 0); chk("rwr_mu", obs.mu, 0); chk("rwr_cnt", obs.cnt, 0);
        for (int i = 1; i <= 20; i++) begin
            samp();
            chk("rwr_re_sv", obs.sv, (i == 20) ? 1 : 0);
        end
        chk("rwr_re_cnt", obs.cnt, 1);

        // Random mix against the model
        for (int i = 0; i < 400; i++) begin
            longint lc, ld;
            lc = longint'($urandom_range(0, 32'h1FFF_FFFF)) - (64'd1 << 28);
            ld = longint'($urandom);
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), lc,
                ($urandom_range(0, 29) == 0), ld);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/timing_nco.md
Name: timing_nco

Overview:
- Interpolator-control NCO for the MSK symbol timing recovery loop.
- Sits directly upstream of the polyphase fractional-delay interpolator. It advances a symbol-phase accumulator once per raw sample and drives the interpolator's integer phase, fractional mu, phase-valid and symbol strobe.
- The step size is the nominal one-sample step plus a signed correction from the timing loop filter. Each strobe marks a symbol instant located phase_int_o + mu_o raw samples before the newest sample.

Parameters:
- OSF, 20, raw samples per symbol; accumulator wraps at OSF.
- MU_W, 27, fractional bits of accumulator, step and mu (Q0.27).
- INT_W, 5, integer bits; must satisfy 2**INT_W > OSF.
- STEP_MIN, 2**26 (0.5 sample), lower clamp on effective step.
- STEP_MAX, 3*2**26 (1.5 samples), upper clamp on effective step; must be < OSF<<MU_W.
- INIT_PH, 0, accumulator value after reset, Q5.27.
- CNT_W, 16, symbol counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- en_i  in  1  advance enable; low freezes the accumulator.
- iq_raw_val_i  in  1  raw sample valid; one accumulator advance per cycle.
- loop_ctrl_i  in  MU_W+2 signed  step correction, Q2.27.
- loop_val_i  in  1  loop_ctrl_i valid.
- ph_load_i  in  INT_W+MU_W  coarse phase to load, Q5.27.
- ph_load_val_i  in  1  load strobe.
- phase_int_o  out  INT_W  integer delay, 0..OSF-1.
- mu_o  out  MU_W  fractional delay, Q0.27.
- phase_val_o  out  1  interpolator shift/phase qualifier.
- sym_valid_o  out  1  one-cycle symbol strobe.
- sym_cnt_o  out  CNT_W  strobes since reset, wrapping.

Behaviour:
- Reset (rst=0 at a clk edge):
  - acc=INIT_PH, step_q=1<<MU_W.
  - All outputs 0: phase_int_o, mu_o, phase_val_o, sym_valid_o, sym_cnt_o.
  - Reset asserted mid-operation aborts any pending strobe and takes effect on that edge.
- Step register:
  - On loop_val_i, step_q <= sat((1<<MU_W) + loop_ctrl_i, STEP_MIN, STEP_MAX).
  - Signed add is evaluated at MU_W+3 bits before clamping.
  - Otherwise step_q holds.
  - A new step applies to the first advance after the cycle in which it was registered. If loop_val_i and iq_raw_val_i coincide, the advance uses the old step_q.
- Advance (en_i=1, iq_raw_val_i=1, no load):
  - s = acc + step_q, computed at INT_W+MU_W+1 bits.
  - If s >= OSF<<MU_W: acc <= s - (OSF<<MU_W) and a wrap is flagged. Otherwise acc <= s.
  - At most one wrap per advance is guaranteed by STEP_MAX.
- Outputs, registered, 1-cycle latency from the advancing iq_raw_val_i:
  - phase_val_o <= 1 on every advance, else 0.
  - On wrap: sym_valid_o <= 1 and {phase_int_o, mu_o} <= residual acc after subtraction, so phase_int_o = residual integer part and mu_o = residual fraction. sym_cnt_o increments and wraps at 2**CNT_W.
  - With no wrap, sym_valid_o <= 0 and phase_int_o/mu_o hold their last strobe values.
- Load:
  - ph_load_val_i sets acc <= ph_load_i; it takes priority over an advance in the same cycle.
  - That sample produces phase_val_o=1 (if iq_raw_val_i and en_i) but never a strobe.
  - A load value >= OSF<<MU_W is reduced by a single subtraction of OSF<<MU_W.
- en_i=0: acc holds, phase_val_o=0, sym_valid_o=0. Loads and step updates are still accepted.
- Gaps in iq_raw_val_i: no advance and no strobe, so strobe spacing is counted in valid samples, not clocks.
- Throughput: one advance per clock; no back-pressure.

Decomposition:
- Package msk_timing_pkg holds:
  - constants OSF, MU_W, INT_W, ONE_SAMPLE=1<<MU_W, SYM_WRAP=OSF<<MU_W;
  - typedefs acc_t (logic [INT_W+MU_W-1:0]), step_t, ctrl_t (signed [MU_W+1:0]), mu_t.
- One sub-module, timing_step_sat: registered saturating add of the nominal step plus correction, with clamp parameters. It is shared with the future loop filter.

Test Plan:
- Nominal step, loop_val_i never asserted, iq_raw_val_i every cycle from reset with INIT_PH=0 -> sym_valid_o pulses on output cycles 20, 40, 60 with phase_int_o=0, mu_o=0; sym_cnt_o=3.
- loop_ctrl_i=2**25 (step 1.25) loaded before the first sample -> strobe every 16 samples, phase_int_o=0, mu_o=0.
- loop_ctrl_i=2**27 (requests 2.0) -> step clamped to 1.5. First strobe after sample 14 with phase_int_o=1, mu_o=0; next after sample 27 with phase_int_o=0, mu_o=2**26.
- ph_load_i=(19<<27)|2**26 with step 1.0; next sample -> strobe with phase_int_o=0, mu_o=2**26. Load coincident with a sample -> no strobe that cycle.
- iq_raw_val_i every 3rd cycle, nominal step -> strobe after each 20th valid sample (60 clocks apart); en_i=0 for 10 cycles -> no phase_val_o or sym_valid_o, strobe delayed by exactly the frozen samples.
- rst=0 asserted on the cycle a wrap is due -> no strobe, all outputs 0, acc=INIT_PH; counting restarts from 0 after release.
